// File: rtl/key_filter_pkg.sv
// Shared definitions for the key_filter debouncer: state encoding, counter
// widths and default timing constants for a 50 MHz system clock.
package key_filter_pkg;

    localparam int unsigned NUM_KEYS_DEF = 4;
    localparam int unsigned CNT_W        = 25;
    localparam int unsigned LCNT_W       = 26;
    localparam int unsigned SYNC_W       = 2;

    // 20 ms debounce window and 1 s long-press time, both minus one
    localparam logic [CNT_W-1:0]  CNT_MAX_DEF  = 25'd999_999;
    localparam logic [LCNT_W-1:0] LONG_MAX_DEF = 26'd49_999_999;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_FILT   = 2'd1,
        ST_DOWN         = 2'd2,
        ST_RELEASE_FILT = 2'd3
    } key_state_t;

endpackage : key_filter_pkg

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM with filter and long-press
// counters, and registered level / press / release / long-press outputs.
module key_debounce_ch
    import key_filter_pkg::*;
#(
    parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
    parameter logic [LCNT_W-1:0] LONG_MAX = LONG_MAX_DEF
)(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    logic [SYNC_W-1:0] r_sync;
    logic              w_key_n;
    key_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LCNT_W-1:0] r_lcnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    // Synchroniser resets to "released" so a key held through reset is a new press
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    assign w_key_n = r_sync[SYNC_W-1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_lcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_key_n) begin
                        r_state <= ST_PRESS_FILT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_FILT: begin
                    if (w_key_n) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= ST_DOWN;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                        r_lcnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    // Counter parks one past LONG_MAX so the long pulse fires once
                    if (r_lcnt == LONG_MAX) begin
                        r_long <= 1'b1;
                    end
                    if (r_lcnt <= LONG_MAX) begin
                        r_lcnt <= r_lcnt + LCNT_W'(1);
                    end
                    if (w_key_n) begin
                        r_state <= ST_RELEASE_FILT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_FILT: begin
                    if (!w_key_n) begin
                        r_state <= ST_DOWN;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                        r_lcnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule : key_debounce_ch

// File: rtl/key_filter.sv
// Debouncer for NUM_KEYS active-low push-buttons; each key is handled by an
// independent key_debounce_ch instance.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int unsigned       NUM_KEYS = NUM_KEYS_DEF,
    parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
    parameter logic [LCNT_W-1:0] LONG_MAX = LONG_MAX_DEF
)(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_flag,
    output logic [NUM_KEYS-1:0] release_flag,
    output logic [NUM_KEYS-1:0] long_flag
);

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .i_key_n   (key_in[g]),
            .o_level   (key_level[g]),
            .o_press   (press_flag[g]),
            .o_release (release_flag[g]),
            .o_long    (long_flag[g])
        );
    end

endmodule : key_filter

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed and random key waveforms scored against a
// run-length reference model through an expected-event queue.
module tb_key_filter;

    localparam int NK       = 4;
    localparam int CNT_MAX  = 9;
    localparam int LONG_MAX = 19;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_flag;
    logic [NK-1:0] release_flag;
    logic [NK-1:0] long_flag;

    key_filter #(
        .NUM_KEYS (NK),
        .CNT_MAX  (25'd9),
        .LONG_MAX (26'd19)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_in       (key_in),
        .key_level    (key_level),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .long_flag    (long_flag)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            cyc;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic [NK-1:0] lg;
    } ev_t;

    ev_t           evq[$];
    logic [NK-1:0] exp_lvl [4] = '{default: '0};
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    // Reference model: a key's debounced state flips once the raw pin has
    // disagreed with it for CNT_MAX+2 consecutive samples; the result shows
    // up two edges after the deciding sample. Long press fires on the
    // (LONG_MAX+1)-th sample spent settled-down since the press.
    initial begin
        int            run [NK];
        int            dcnt [NK];
        logic          deb [NK];
        logic          p;
        logic [NK-1:0] lvl;
        ev_t           e;
        for (int i = 0; i < NK; i++) begin
            run[i] = 0; dcnt[i] = 0; deb[i] = 1'b0;
        end
        forever begin
            @(posedge sys_clk);
            cyc++;
            if (!sys_rst_n) begin
                for (int i = 0; i < NK; i++) begin
                    run[i] = 0; dcnt[i] = 0; deb[i] = 1'b0;
                end
                for (int k = 0; k < 4; k++) exp_lvl[k] = '0;
                while (evq.size() > 0 && evq[$].cyc >= cyc) void'(evq.pop_back());
            end else begin
                e.cyc = cyc + 2; e.pr = '0; e.rl = '0; e.lg = '0;
                for (int i = 0; i < NK; i++) begin
                    p = ~key_in[i];
                    if (deb[i] && run[i] == 0) begin
                        dcnt[i]++;
                        if (dcnt[i] == LONG_MAX + 1) e.lg[i] = 1'b1;
                    end
                    if (p != deb[i]) begin
                        run[i]++;
                        if (run[i] == CNT_MAX + 2) begin
                            deb[i]  = p;
                            run[i]  = 0;
                            dcnt[i] = 0;
                            if (p) e.pr[i] = 1'b1;
                            else   e.rl[i] = 1'b1;
                        end
                    end else begin
                        run[i] = 0;
                    end
                    lvl[i] = deb[i];
                end
                exp_lvl[(cyc + 2) % 4] = lvl;
                if ((e.pr | e.rl | e.lg) != '0) evq.push_back(e);
            end
        end
    end

    // Monitor: level every cycle, flags whenever any are raised
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            total++;
            if (key_level !== exp_lvl[cyc % 4]) begin
                bad++;
                $display("FAIL level cyc=%0d got=%b want=%b", cyc, key_level, exp_lvl[cyc % 4]);
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL missing_flags cyc=%0d got none want pr=%b rl=%b lg=%b",
                         evq[0].cyc, evq[0].pr, evq[0].rl, evq[0].lg);
                void'(evq.pop_front());
            end
            if ((press_flag | release_flag | long_flag) !== '0) begin
                total++;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    if (press_flag !== evq[0].pr || release_flag !== evq[0].rl ||
                        long_flag !== evq[0].lg) begin
                        bad++;
                        $display("FAIL flags cyc=%0d got pr=%b rl=%b lg=%b want pr=%b rl=%b lg=%b",
                                 cyc, press_flag, release_flag, long_flag,
                                 evq[0].pr, evq[0].rl, evq[0].lg);
                    end
                    void'(evq.pop_front());
                end else begin
                    bad++;
                    $display("FAIL unexpected_flags cyc=%0d got pr=%b rl=%b lg=%b want none",
                             cyc, press_flag, release_flag, long_flag);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        int hold [NK];

        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(5);

        // Clean press on key 0 with long press
        key_in[0] = 1'b0; wait_cyc(40);
        key_in[0] = 1'b1; wait_cyc(20);

        // Bouncing key 1, then settled low
        for (int t = 0; t < 10; t++) begin
            key_in[1] = ~key_in[1]; wait_cyc(3);
        end
        key_in[1] = 1'b0; wait_cyc(20);
        key_in[1] = 1'b1; wait_cyc(20);

        // Short press and release on key 2 (no long press)
        key_in[2] = 1'b0; wait_cyc(20);
        key_in[2] = 1'b1; wait_cyc(20);

        // Keys 0 and 3 together, release key 0 alone first
        key_in[0] = 1'b0; key_in[3] = 1'b0; wait_cyc(20);
        key_in[0] = 1'b1; wait_cyc(20);
        key_in[3] = 1'b1; wait_cyc(20);

        // Reset in the middle of the press filter with the key held
        key_in[1] = 1'b0; wait_cyc(8);
        sys_rst_n = 1'b0; wait_cyc(2);
        sys_rst_n = 1'b1; wait_cyc(20);
        key_in[1] = 1'b1; wait_cyc(20);

        // Single-cycle glitch
        key_in[0] = 1'b0; wait_cyc(1);
        key_in[0] = 1'b1; wait_cyc(20);

        // Random waveforms: mix of bounces, normal and long presses
        for (int i = 0; i < NK; i++) hold[i] = $urandom_range(1, 40);
        for (int n = 0; n < 3000; n++) begin
            @(negedge sys_clk);
            if (n == 1500) sys_rst_n = 1'b0;
            if (n == 1502) sys_rst_n = 1'b1;
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    key_in[i] = ~key_in[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                          : $urandom_range(5, 45);
                end else begin
                    hold[i]--;
                end
            end
        end
        key_in = '1;
        wait_cyc(40);

        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL leftover_events got=%0d want=0", evq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_filter

// File: doc/key_filter.md
Name: key_filter

Overview:
- Input-side counterpart to the board's active-low LED drivers: debounces NUM_KEYS active-low push-buttons.
- Emits clean one-cycle press, release and long-press pulses plus a debounced level per key.
- Sits between board pins and any mode/pattern control logic, e.g. selecting LED direction or speed.
- Channels are fully independent; one sub-module instance per key.

Parameters:
- NUM_KEYS, 4, number of key channels.
- CNT_MAX, 25'd999_999, debounce window minus 1 (20 ms at 50 MHz).
- LONG_MAX, 26'd49_999_999, held time minus 1 after press_flag before long_flag (1 s at 50 MHz).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  reset; asynchronous, active-low.
- key_in  input  NUM_KEYS  raw key pins; active-low (0 = pressed); asynchronous to sys_clk.
- key_level  output  NUM_KEYS  debounced state; 1 = pressed.
- press_flag  output  NUM_KEYS  one-cycle pulse on debounced press.
- release_flag  output  NUM_KEYS  one-cycle pulse on debounced release.
- long_flag  output  NUM_KEYS  one-cycle pulse when a key is held LONG_MAX+1 cycles beyond press_flag.

Behaviour:
- Reset values: key_level=0, all flags=0, synchronisers=all 1 (released), every FSM in IDLE, all counters 0.
- Synchroniser: 2-FF per bit. Below, "k" is the synchronised, active-low key value.
- Per-channel FSM:
  - IDLE: if k==0 -> PRESS_FILT with cnt=0.
  - PRESS_FILT: if k==1 -> IDLE (bounce, no flag). Else if cnt==CNT_MAX -> DOWN and press_flag=1 next cycle. Else cnt++.
  - DOWN: key_level=1; long counter increments each cycle. When lcnt==LONG_MAX: long_flag=1 for one cycle; lcnt saturates, so there is no repeat. If k==1 -> RELEASE_FILT with cnt=0.
  - RELEASE_FILT: if k==0 -> DOWN (bounce; lcnt keeps its value and is not cleared). Else if cnt==CNT_MAX -> IDLE, release_flag=1 next cycle, key_level=0, lcnt=0. Else cnt++.
- Latency:
  - press_flag rises exactly CNT_MAX+4 rising edges after the first edge sampling key_in low: 2 sync + CNT_MAX+1 filter + 1 output register. release_flag has the same latency.
  - key_level changes in the same cycle as the corresponding flag.
- Flags are registered, exactly 1 cycle wide, and never asserted in the same cycle as each other on one channel.
- Counter widths: cnt is 25 bits and lcnt is 26 bits. Neither counter ever wraps.
- Simultaneous activity on several keys is handled independently with no priority.
- Reset mid-operation: immediate return to reset values; a key held through reset deassertion is treated as a new press, i.e. it must pass a full filter window.
- Glitch shorter than 2 cycles may never reach the FSM; any bounce inside a filter window restarts filtering from the prior stable state.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, PRESS_FILT=2'd1, DOWN=2'd2, RELEASE_FILT=2'd3) and default CNT_MAX/LONG_MAX values at 50 MHz.
- Sub-module key_debounce_ch: one channel (synchroniser, FSM, both counters, 4 outputs).
- key_filter is a generate loop of NUM_KEYS instances.

Test Plan (CNT_MAX=9, LONG_MAX=19 for simulation):
- Clean press: key_in[0] 1->0 held 40 cycles -> press_flag[0] one cycle at edge 13, key_level[0]=1 from edge 13, long_flag[0] one cycle at edge 33; no other flags.
- Bounce: key_in[1] toggles 0/1 every 3 cycles for 30 cycles then settles 0 -> no flag during toggling; press_flag[1] exactly once, 13 edges after settling.
- Release: after a debounced press on key 2, key_in[2] 0->1 -> release_flag[2] one cycle 13 edges later, key_level[2]=0; long_flag never fired if held under LONG_MAX+1 after press.
- Multi-key: keys 0 and 3 pressed on the same edge -> press_flag=4'b1001 in a single cycle; releasing key 0 alone leaves key_level=4'b1000.
- Reset mid-filter: assert sys_rst_n=0 at filter count 5 while key held, deassert -> all outputs 0 immediately; press_flag appears 13 edges after reset release.
- Short glitch: key_in[0] low for 1 cycle -> no flags, key_level unchanged.
